run_event_monitor: RTL
======================

// Module: run_event_monitor
// PURPOSE
//  Consumes the 4-bit state code z of the w-sequence detector FSM.
//  The FSM codes are A=0, B..D=1..3, E=4 (zero-run), F..H=5..7, I=8 (one-run).
//  Tracks zero-runs (code E) and one-runs (code I), measures how long each is held, and counts entries.
//  Posts one event record per completed run on a valid/ready port for the downstream logger/display.
//  Flags illegal codes 9..15.
// PARAMETERS
//  CNT_W  8  width of saturating run-entry counters zero_count/one_count
//  LEN_W  8  width of run-length field evt_len; saturates at 2^LEN_W-1
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  reset       in   1      synchronous, active-high; clears all state
//  z_in        in   4      FSM state code (z)
//  clear       in   1      sync clear of counters and sticky flags
//  zero_run    out  1      registered: current code is E
//  one_run     out  1      registered: current code is I
//  zero_pulse  out  1      1-cycle pulse on entry to E
//  one_pulse   out  1      1-cycle pulse on entry to I
//  zero_count  out  CNT_W  E entries since reset/clear, saturating
//  one_count   out  CNT_W  I entries since reset/clear, saturating
//  evt_valid   out  1      event record available
//  evt_ready   in   1      consumer accepts record when evt_valid&&evt_ready
//  evt_type    out  1      0=zero-run, 1=one-run
//  evt_len     out  LEN_W  cycles the run code was held
//  evt_ovf     out  1      sticky: event dropped, buffer busy
//  err_illegal out  1      sticky: z_in code 9..15 seen
// BEHAVIOUR
//  Reset values (reset=1 at posedge): every output 0, internal z_q=0, monitor state M_IDLE, run_len=0.
//  Reset overrides clear and every other input.
//  Stage 1: z_q <= z_in each edge.
//  Stage 2: all outputs register from z_q.
//    Total latency z_in -> outputs is 2 cycles.
//  Monitor FSM, evaluated on z_q:
//   M_IDLE: z_q==4 -> M_RUN0, run_len=1, zero_pulse=1, zero_count++.
//           z_q==8 -> M_RUN1, run_len=1, one_pulse=1, one_count++.
//           Otherwise stay.
//   M_RUN0: z_q==4 -> stay, run_len++ (saturate).
//           z_q==8 -> end run0 and enter M_RUN1 in the same edge.
//           Otherwise end run0 and go to M_IDLE.
//   M_RUN1: symmetric to M_RUN0 with codes 8/4 swapped.
//   Ending a run: post event {type, run_len}.
//  zero_run=(state==M_RUN0); one_run=(state==M_RUN1); pulses are high only on the entry edge.
//  Illegal z_q (>8): err_illegal<=1.
//    Any open run ends (event posted) and FSM goes to M_IDLE.
//    Illegal codes never count as runs.
//  Event slot: single entry.
//    Post with slot empty, or with evt_valid&&evt_ready on the same edge -> load, evt_valid=1.
//    Post with slot busy and not being accepted -> record dropped, evt_ovf<=1, held record unchanged.
//    Acceptance with no new post -> evt_valid<=0.
//    evt_type/evt_len stay stable while evt_valid&&!evt_ready.
//  Counters zero_count/one_count saturate at 2^CNT_W-1 and never wrap.
//  clear=1: zero_count, one_count, evt_ovf and err_illegal <=0.
//    Run tracking and event slot unaffected.
//    An increment on the same edge as clear is lost; clear wins.
//  Reset mid-run: run discarded, no event posted.
// TESTING
//  1. z_in=0,1,2,3,4,4,4,5: zero_pulse once, 2 cycles after first 4; zero_count=1.
//     Then evt_valid, evt_type=0, evt_len=3.
//  2. z_in=8 held 300 cycles then 1, LEN_W=8, evt_ready=1: one_count=1; event evt_type=1, evt_len=255.
//  3. evt_ready=0; complete two runs (4x2 then 8x1): first record held {0,2}, evt_ovf=1.
//     evt_ready=1 -> evt_valid drops next cycle.
//  4. Enter E 300 times with CNT_W=8: zero_count=255.
//     clear=1 for one cycle -> zero_count=0, err_illegal=0, evt_ovf=0.
//  5. z_in=4,4,12: err_illegal=1; event {0,2} posted; state M_IDLE; zero_run=0.
//  6. reset=1 during a one-run of length 5: all outputs 0 next cycle; no event after reset release.

Source files
------------

// File: rtl/run_event_monitor.sv
// run_event_monitor
//   Watches the 4-bit state code of the w-sequence detector FSM. It tracks
//   zero-runs (code 4) and one-runs (code 8) and measures how long each one
//   lasts. It counts run entries and flags illegal codes (9..15). For every
//   completed run it posts one {type, length} record to a single-entry
//   valid/ready slot.
//
// Ports
//   clk, reset      single clock; synchronous active-high reset
//   z_in            detector state code, registered once into z_q
//   clear           clears zero_count, one_count, evt_ovf, err_illegal
//   zero_run        current (pipelined) code is 4
//   one_run         current (pipelined) code is 8
//   zero_pulse      one-cycle pulse on entry to a zero-run
//   one_pulse       one-cycle pulse on entry to a one-run
//   zero_count      saturating count of zero-run entries
//   one_count       saturating count of one-run entries
//   evt_valid       record held in the slot
//   evt_ready       consumer ready
//   evt_type        0 = zero-run, 1 = one-run
//   evt_len         run length in cycles, saturating
//   evt_ovf         sticky: a record was dropped because the slot was busy
//   err_illegal     sticky: an illegal code was seen
//   mon_state       debug view of the monitor FSM (0 idle, 1 run0, 2 run1)
//
// Handshake: a record transfers on any edge where evt_valid && evt_ready.
// While evt_valid is high and evt_ready is low, evt_type and evt_len hold.
// A new record posted on the same edge as a transfer replaces the one that
// is leaving.
module run_event_monitor #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       z_in,
  input  logic             clear,
  output logic             zero_run,
  output logic             one_run,
  output logic             zero_pulse,
  output logic             one_pulse,
  output logic [CNT_W-1:0] zero_count,
  output logic [CNT_W-1:0] one_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_type,
  output logic [LEN_W-1:0] evt_len,
  output logic             evt_ovf,
  output logic             err_illegal,
  output logic [1:0]       mon_state
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_RUN0 = 2'd1,
    M_RUN1 = 2'd2
  } mon_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  mon_state_t       state, state_n;
  logic [3:0]       z_q;
  logic [LEN_W-1:0] run_len;
  logic             enter0, enter1, post, post_type, illegal;

  assign mon_state = state;

  // Next state and run bookkeeping. Any code other than the current run's
  // own code ends that run. An illegal code falls out to M_IDLE here too,
  // because it is neither 4 nor 8.
  always_comb begin
    state_n   = state;
    enter0    = 1'b0;
    enter1    = 1'b0;
    post      = 1'b0;
    post_type = 1'b0;
    illegal   = (z_q > 4'd8);
    case (state)
      M_IDLE: begin
        if (z_q == 4'd4) begin
          state_n = M_RUN0;
          enter0  = 1'b1;
        end else if (z_q == 4'd8) begin
          state_n = M_RUN1;
          enter1  = 1'b1;
        end
      end
      M_RUN0: begin
        if (z_q != 4'd4) begin
          post      = 1'b1;
          post_type = 1'b0;
          if (z_q == 4'd8) begin
            state_n = M_RUN1;
            enter1  = 1'b1;
          end else begin
            state_n = M_IDLE;
          end
        end
      end
      M_RUN1: begin
        if (z_q != 4'd8) begin
          post      = 1'b1;
          post_type = 1'b1;
          if (z_q == 4'd4) begin
            state_n = M_RUN0;
            enter0  = 1'b1;
          end else begin
            state_n = M_IDLE;
          end
        end
      end
      default: state_n = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= M_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q         <= '0;
      run_len     <= '0;
      zero_run    <= 1'b0;
      one_run     <= 1'b0;
      zero_pulse  <= 1'b0;
      one_pulse   <= 1'b0;
      zero_count  <= '0;
      one_count   <= '0;
      evt_valid   <= 1'b0;
      evt_type    <= 1'b0;
      evt_len     <= '0;
      evt_ovf     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      z_q        <= z_in;
      zero_run   <= (state_n == M_RUN0);
      one_run    <= (state_n == M_RUN1);
      zero_pulse <= enter0;
      one_pulse  <= enter1;

      if (enter0 || enter1) begin
        run_len <= {{(LEN_W-1){1'b0}}, 1'b1};
      end else if (state_n == M_IDLE) begin
        run_len <= '0;
      end else if (run_len != LEN_MAX) begin
        run_len <= run_len + 1'b1;
      end

      // The slot can take a new record if it is empty or is being drained
      // on this same edge.
      if (post) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_type  <= post_type;
          evt_len   <= run_len;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (enter0 && zero_count != CNT_MAX) zero_count <= zero_count + 1'b1;
      if (enter1 && one_count != CNT_MAX)  one_count  <= one_count + 1'b1;
      if (illegal) err_illegal <= 1'b1;

      // clear comes last, so it wins over any increment or flag set on the
      // same edge.
      if (clear) begin
        zero_count  <= '0;
        one_count   <= '0;
        evt_ovf     <= 1'b0;
        err_illegal <= 1'b0;
      end
    end
  end

endmodule
